// File: rtl/mag_pixel_out.sv
// mag_pixel_out
//   Stream sink for the Sobel gradient-magnitude stream. Each accepted
//   magnitude is converted to a PIX_W_P-bit pixel and tagged with raster
//   position markers. The pixel is either saturating grey or a binary
//   threshold of the magnitude. The output is registered and backed by a
//   one-entry skid register, so the block runs at full throughput.
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   rst_i        : synchronous active-high reset
//   valid_i      : magnitude beat valid
//   ready_o      : sink can accept a beat (registered, "skid empty")
//   mag_i        : unsigned magnitude, 2*WIDTH_P bits
//   bin_en_i     : 1 = binary threshold, 0 = saturating grey (latched per frame)
//   thresh_i     : binary threshold (latched per frame)
//   valid_o      : output pixel valid
//   ready_i      : downstream accepts the pixel
//   pix_o        : output pixel
//   sof_o        : pixel is (row 0, col 0)
//   eol_o        : pixel is the last column of its line
//   eof_o        : pixel is the last pixel of the frame
//   frame_done_o : one-cycle pulse after the eof pixel transfers out
module mag_pixel_out #(
  parameter int WIDTH_P = 8,
  parameter int PIX_W_P = 8,
  parameter int H_RES_P = 640,
  parameter int V_RES_P = 480
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2*WIDTH_P-1:0]   mag_i,
  input  logic                   bin_en_i,
  input  logic [2*WIDTH_P-1:0]   thresh_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [PIX_W_P-1:0]     pix_o,
  output logic                   sof_o,
  output logic                   eol_o,
  output logic                   eof_o,
  output logic                   frame_done_o
);

  localparam int MAG_W_C = 2 * WIDTH_P;
  localparam int COL_W_C = (H_RES_P > 1) ? $clog2(H_RES_P) : 1;
  localparam int ROW_W_C = (V_RES_P > 1) ? $clog2(V_RES_P) : 1;
  // Largest pixel value expressed at full magnitude width, so the
  // saturation compare never truncates the magnitude.
  localparam logic [MAG_W_C-1:0] PIX_MAX_C = {MAG_W_C{1'b1}} >> (MAG_W_C - PIX_W_P);
  localparam logic [COL_W_C-1:0] COL_LAST_C = COL_W_C'(H_RES_P - 1);
  localparam logic [ROW_W_C-1:0] ROW_LAST_C = ROW_W_C'(V_RES_P - 1);

  typedef struct packed {
    logic [PIX_W_P-1:0] pix;
    logic               sof;
    logic               eol;
    logic               eof;
  } beat_t;

  // Magnitude-to-pixel conversion for both modes.
  function automatic logic [PIX_W_P-1:0] convert_pix(
    input logic [MAG_W_C-1:0] mag,
    input logic               bin_en,
    input logic [MAG_W_C-1:0] thresh
  );
    logic [PIX_W_P-1:0] pix;
    if (bin_en) begin
      pix = (mag >= thresh) ? {PIX_W_P{1'b1}} : {PIX_W_P{1'b0}};
    end else if (mag > PIX_MAX_C) begin
      pix = {PIX_W_P{1'b1}};
    end else begin
      pix = mag[PIX_W_P-1:0];
    end
    return pix;
  endfunction

  logic                 ready_r;
  logic                 out_valid_r;
  beat_t                out_beat_r;
  logic                 skid_valid_r;
  beat_t                skid_beat_r;
  logic                 frame_done_r;
  logic [COL_W_C-1:0]   col_r;
  logic [ROW_W_C-1:0]   row_r;
  logic                 bin_en_r;
  logic [MAG_W_C-1:0]   thresh_r;

  logic                 accept_s;
  logic                 xfer_s;
  logic                 first_px_s;
  logic                 use_bin_s;
  logic [MAG_W_C-1:0]   use_thresh_s;
  beat_t                new_beat_s;
  logic                 out_valid_n_s;
  beat_t                out_beat_n_s;
  logic                 skid_valid_n_s;
  beat_t                skid_beat_n_s;
  logic [COL_W_C-1:0]   col_n_s;
  logic [ROW_W_C-1:0]   row_n_s;
  logic                 bin_en_n_s;
  logic [MAG_W_C-1:0]   thresh_n_s;

  // Handshakes, per-beat conversion and marker generation.
  always_comb begin
    accept_s   = valid_i && ready_r;
    xfer_s     = out_valid_r && ready_i;
    first_px_s = (col_r == {COL_W_C{1'b0}}) && (row_r == {ROW_W_C{1'b0}});
    // The first beat of a frame already uses the controls it latches.
    if (first_px_s) begin
      use_bin_s    = bin_en_i;
      use_thresh_s = thresh_i;
    end else begin
      use_bin_s    = bin_en_r;
      use_thresh_s = thresh_r;
    end
    new_beat_s.pix = convert_pix(mag_i, use_bin_s, use_thresh_s);
    new_beat_s.sof = first_px_s;
    new_beat_s.eol = (col_r == COL_LAST_C);
    new_beat_s.eof = (col_r == COL_LAST_C) && (row_r == ROW_LAST_C);
  end

  // Output/skid register next state; the skid only fills while the output is stalled.
  always_comb begin
    out_valid_n_s  = out_valid_r;
    out_beat_n_s   = out_beat_r;
    skid_valid_n_s = skid_valid_r;
    skid_beat_n_s  = skid_beat_r;
    if (!out_valid_r || xfer_s) begin
      if (skid_valid_r) begin
        out_valid_n_s  = 1'b1;
        out_beat_n_s   = skid_beat_r;
        skid_valid_n_s = 1'b0;
      end else if (accept_s) begin
        out_valid_n_s = 1'b1;
        out_beat_n_s  = new_beat_s;
      end else begin
        out_valid_n_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_n_s = 1'b1;
        skid_beat_n_s  = new_beat_s;
      end else begin
        skid_valid_n_s = skid_valid_r;
      end
    end
  end

  // Raster counters and frame-latched controls, advanced on accept only.
  always_comb begin
    col_n_s    = col_r;
    row_n_s    = row_r;
    bin_en_n_s = bin_en_r;
    thresh_n_s = thresh_r;
    if (accept_s) begin
      if (col_r == COL_LAST_C) begin
        col_n_s = {COL_W_C{1'b0}};
        if (row_r == ROW_LAST_C) begin
          row_n_s = {ROW_W_C{1'b0}};
        end else begin
          row_n_s = row_r + ROW_W_C'(1);
        end
      end else begin
        col_n_s = col_r + COL_W_C'(1);
        row_n_s = row_r;
      end
      if (first_px_s) begin
        bin_en_n_s = bin_en_i;
        thresh_n_s = thresh_i;
      end else begin
        bin_en_n_s = bin_en_r;
        thresh_n_s = thresh_r;
      end
    end else begin
      col_n_s = col_r;
      row_n_s = row_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_r      <= 1'b0;
      out_valid_r  <= 1'b0;
      out_beat_r   <= '{pix: {PIX_W_P{1'b0}}, sof: 1'b0, eol: 1'b0, eof: 1'b0};
      skid_valid_r <= 1'b0;
      skid_beat_r  <= '{pix: {PIX_W_P{1'b0}}, sof: 1'b0, eol: 1'b0, eof: 1'b0};
      frame_done_r <= 1'b0;
      col_r        <= {COL_W_C{1'b0}};
      row_r        <= {ROW_W_C{1'b0}};
      bin_en_r     <= 1'b0;
      thresh_r     <= {MAG_W_C{1'b0}};
    end else begin
      // ready follows the skid occupancy one cycle later, never ready_i.
      ready_r      <= !skid_valid_n_s;
      out_valid_r  <= out_valid_n_s;
      out_beat_r   <= out_beat_n_s;
      skid_valid_r <= skid_valid_n_s;
      skid_beat_r  <= skid_beat_n_s;
      frame_done_r <= xfer_s && out_beat_r.eof;
      col_r        <= col_n_s;
      row_r        <= row_n_s;
      bin_en_r     <= bin_en_n_s;
      thresh_r     <= thresh_n_s;
    end
  end

  assign ready_o      = ready_r;
  assign valid_o      = out_valid_r;
  assign pix_o        = out_beat_r.pix;
  assign sof_o        = out_beat_r.sof;
  assign eol_o        = out_beat_r.eol;
  assign eof_o        = out_beat_r.eof;
  assign frame_done_o = frame_done_r;

endmodule

// File: doc/mag_pixel_out.md
# mag_pixel_out

Stream sink for the Sobel gradient-magnitude stream. Accepts 2*WIDTH_P-bit magnitudes over valid/ready, converts each to a PIX_W_P-bit output pixel (saturating grey or binary threshold), and tags every pixel with raster position markers. Sits between the magnitude stage and the video/frame-buffer writer. Registered, skid-buffered, full-throughput.

## Interface
- WIDTH_P, 8, gradient component width; input magnitude is 2*WIDTH_P bits
- PIX_W_P, 8, output pixel width; requires PIX_W_P <= 2*WIDTH_P
- H_RES_P, 640, pixels per line (>= 2)
- V_RES_P, 480, lines per frame (>= 1)

- clk_i  in  1  single clock; all logic on the rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  magnitude beat valid
- ready_o  out  1  sink can accept a beat
- mag_i  in  2*WIDTH_P  unsigned magnitude
- bin_en_i  in  1  1 = binary threshold mode, 0 = saturating grey mode
- thresh_i  in  2*WIDTH_P  binary threshold, unsigned
- valid_o  out  1  output pixel valid
- ready_i  in  1  downstream accepts the pixel
- pix_o  out  PIX_W_P  output pixel
- sof_o  out  1  pixel is (row 0, col 0)
- eol_o  out  1  pixel is col H_RES_P-1
- eof_o  out  1  pixel is last of frame (eol and row V_RES_P-1)
- frame_done_o  out  1  one-cycle pulse when the eof pixel is accepted downstream

## Operation
- Input accept: valid_i && ready_o. Output transfer: valid_o && ready_i.
- Pixel conversion on accept, using the mode and threshold in effect for the current frame:
  - Grey: pix = mag_i if mag_i <= 2^PIX_W_P-1, otherwise 2^PIX_W_P-1 (all ones). Compare at full 2*WIDTH_P width; never truncate.
  - Binary: pix = all ones if mag_i >= thresh, otherwise 0.
- Frame-latched controls: bin_en_i and thresh_i are captured on the cycle a beat is accepted with col==0 && row==0. That beat and every later beat of the frame use the captured values. Changes mid-frame take effect at the next frame.
- Position counters col (0..H_RES_P-1) and row (0..V_RES_P-1) advance only on input accept.
  - col wraps to 0 after H_RES_P-1 and increments row.
  - row wraps to 0 after V_RES_P-1.
- Markers are computed from the pre-increment col/row and travel with the pixel.
- Buffering: one output register plus one skid register, each holding {pix, sof, eol, eof}.
  - ready_o is a registered signal equal to "skid register empty".
  - When the output register is full and stalled and a beat is accepted, the beat goes to the skid register and ready_o drops on the next cycle.
  - When the output drains, the skid entry moves to the output register and ready_o returns high.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset (rst_i high at an edge): valid_o=0, ready_o=0, pix_o=0, sof_o=eol_o=eof_o=0, frame_done_o=0, col=row=0, skid empty, latched mode=grey, latched thresh=0.
- First cycle after rst_i deasserts: ready_o=1.
- Reset mid-frame: in-flight pixels are discarded, counters return to 0, and the next accepted beat is sof.
- Latency: a beat accepted at edge N appears on valid_o/pix_o after edge N (1 cycle) when the output register is empty or draining.
- Throughput: 1 beat/cycle while ready_i is held high.
- Simultaneous accept and transfer with the output register full: the new beat replaces the output register. The skid is not used.
- valid_o and its payload hold stable while valid_o && !ready_i.
- ready_o depends only on registers; there is no combinational path from ready_i.
- frame_done_o: high for exactly the one cycle after the edge at which the eof pixel transfers out.

## Test plan
- Grey saturation (WIDTH_P=8, PIX_W_P=8), ready_i=1, inputs mag 0, 200, 255, 256, 65535 -> pix 0, 200, 255, 255, 255; each pixel appears 1 cycle after accept; no stalls.
- Binary mode, thresh_i=100 latched at sof, inputs 99, 100, 101 -> pix 0, 255, 255. Change thresh_i to 0 mid-frame -> remaining pixels still use 100; new threshold applies from next sof.
- Markers (H_RES_P=4, V_RES_P=2), 16 beats continuous:
  - sof on beats 0 and 8.
  - eol on beats 3, 7, 11, 15.
  - eof on beats 7 and 15.
  - frame_done_o pulses once per frame, one cycle after the eof transfer.
- Backpressure: ready_i=0 for 3 cycles while valid_i=1:
  - Exactly 2 beats are accepted (output + skid), then ready_o=0 from the following cycle.
  - Release ready_i -> output sequence is in order with no loss; ready_o returns to 1 one cycle after the skid drains.
- Random valid_i/ready_i at 50% over 1000 beats -> output stream equals the reference model; payload stable during stalls.
- Assert rst_i for 1 cycle mid-line (col=2) -> valid_o=0 and ready_o=0 during reset, ready_o=1 the next cycle; the first post-reset pixel has sof=1.
